alu32: RTL and testbench
========================

// Module: alu32
// PURPOSE
//  32-bit integer ALU for the single-cycle MIPS datapath: AND, OR, ADD-with-carry, SUB-with-carry.
//  Combinational compute core; result, carry-out and zero flag are registered (1-cycle latency).
//  Feeds register writeback and the branch-compare zero test.
// PARAMETERS
//  WIDTH  32  operand/result width; ports below assume the default.
// PORTS
//  clk     in   1   rising-edge clock
//  rst_n   in   1   reset, synchronous, active-low
//  result  out  32  registered ALU result
//  Cout    out  1   registered carry-out (arithmetic ops only)
//  zero    out  1   registered flag, 1 when result == 0
//  A       in   32  operand A
//  B       in   32  operand B
//  Cin     in   1   carry-in to adder (ops 2 and 3)
//  opcode  in   2   operation select
// BEHAVIOUR
//  - One clock: clk. Reset is synchronous and active-low: rst_n sampled low at a rising clk edge.
//  - Reset values: result=0, Cout=0, zero=1 (consistent with result 0). Reset wins over any input.
//  - Op decode (comb):
//    - 2'd0 AND: A&B, Cout=0.
//    - 2'd1 OR: A|B, Cout=0.
//    - 2'd2 ADD: {Cout,result}=A+B+Cin.
//    - 2'd3 SUB: {Cout,result}=A+~B+Cin. Cin=1 gives A-B; Cout=1 means no borrow.
//  - Adder: 32-bit ripple-carry built from 1-bit full-adder cells via generate; B passes through an XOR inverter for op 3.
//  - zero = ~|next_result; computed from the same value being registered, all ops.
//  - Latency: inputs sampled at edge N appear on outputs after edge N; outputs hold between edges.
//  - Arithmetic is modulo 2^32; carry out of bit 31 goes only to Cout. No X propagation:
//    - unknown opcode cannot occur (full 2-bit decode).
//  - Reset mid-operation: operation in flight is discarded; first valid result follows the first edge with rst_n=1.
// CONFIGURATION
//  ALU32_OVERFLOW_EN defined: extra port overflow (out, 1), registered with the other outputs.
//   - ADD/SUB: overflow = signed overflow = carry into bit31 XOR carry out of bit31.
//   - AND/OR: overflow = 0; reset value 0.
//  Undefined: port absent, no overflow logic; all other behaviour identical.
// TESTING
//  1 A=0xce42,B=0x5efb,Cin=1: op0->0x4e42; op1->0xdefb; op2->0x12d3e; op2,Cin=0->0x12d3d; Cout=0, zero=0.
//  2 A=0x56e0,B=0xa759,Cin=1: op0->0x0640; op1->0xf7f9; op2->0xfe3a; op2,Cin=0->0xfe39.
//  3 A=0,B=0xa759: op0->0x0, zero=1; op1->0xa759, zero=0; op2,Cin=1->0xa75a.
//  4 A=0xFFFFFFFF,B=0,Cin=1,op2 -> result=0, Cout=1, zero=1; (overflow=0 if ALU32_OVERFLOW_EN).
//  5 op3,Cin=1: A=5,B=5 -> 0,Cout=1,zero=1; A=3,B=5 -> 0xFFFFFFFE,Cout=0; A=0x7FFFFFFF,B=0xFFFFFFFF -> 0x80000000, overflow=1.
//  6 rst_n=0 for one edge while op2 active -> result=0,Cout=0,zero=1 next cycle; every result lags its inputs by exactly 1 edge.

Source files
------------

// File: rtl/alu32.sv
// 32-bit registered ALU: AND, OR, ADD/SUB with carry, zero flag.
// Define ALU32_OVERFLOW_EN to add a registered signed-overflow output.
module alu32_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module alu32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] result,
    output logic             Cout,
    output logic             zero,
`ifdef ALU32_OVERFLOW_EN
    output logic             overflow,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [1:0]       opcode
);
    logic             op_and;
    logic             op_or;
    logic             op_add;
    logic             op_sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] next_result;
    logic             next_cout;
    logic             next_ovf;

    assign op_and = (opcode == 2'd0);
    assign op_or  = (opcode == 2'd1);
    assign op_add = (opcode == 2'd2);
    assign op_sub = (opcode == 2'd3);

    // Subtract is A + ~B + Cin through the same ripple chain
    assign bx       = B ^ {WIDTH{op_sub}};
    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        alu32_fa u_fa (
            .a  (A[i]),
            .b  (bx[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    always_comb begin
        next_result = '0;
        next_cout   = 1'b0;
        next_ovf    = 1'b0;
        unique case (1'b1)
            op_and: next_result = A & B;
            op_or:  next_result = A | B;
            op_add, op_sub: begin
                next_result = sum;
                next_cout   = carry[WIDTH];
                next_ovf    = carry[WIDTH] ^ carry[WIDTH-1];
            end
            default: next_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            Cout   <= 1'b0;
            zero   <= 1'b1;
        end else begin
            result <= next_result;
            Cout   <= next_cout;
            zero   <= ~|next_result;
        end
    end

`ifdef ALU32_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (!rst_n) overflow <= 1'b0;
        else        overflow <= next_ovf;
    end
`else
    logic unused_ovf;
    assign unused_ovf = next_ovf;
`endif
endmodule

// File: tb/tb_alu32.sv
// Directed self-checking bench for alu32.
// Expected values are hand-computed from the operation definitions.
module tb_alu32;
    logic        clk;
    logic        rst_n;
    logic [31:0] result;
    logic        Cout;
    logic        zero;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic [1:0]  opcode;
`ifdef ALU32_OVERFLOW_EN
    logic        overflow;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    alu32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .result   (result),
        .Cout     (Cout),
        .zero     (zero),
`ifdef ALU32_OVERFLOW_EN
        .overflow (overflow),
`endif
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .opcode   (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ci);
        opcode = op;
        A      = a;
        B      = b;
        Cin    = ci;
    endtask

    task automatic step(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic [31:0] er,
                        input logic ec, input logic ez, input logic eo);
        drive(op, a, b, ci);
        @(posedge clk);
        #1;
        chk({tag, ".result"}, result, er);
        chk({tag, ".cout"}, {31'd0, Cout}, {31'd0, ec});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
`ifdef ALU32_OVERFLOW_EN
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("unreachable");
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'd2, 32'h1234, 32'h4321, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.result", result, 32'h0);
        chk("rst.cout", {31'd0, Cout}, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd1);
`ifdef ALU32_OVERFLOW_EN
        chk("rst.ovf", {31'd0, overflow}, 32'd0);
`endif
        rst_n = 1'b1;

        step("t1.and", 2'd0, 32'hce42, 32'h5efb, 1'b1, 32'h4e42, 0, 0, 0);
        step("t1.or",  2'd1, 32'hce42, 32'h5efb, 1'b1, 32'hdefb, 0, 0, 0);
        step("t1.add", 2'd2, 32'hce42, 32'h5efb, 1'b1, 32'h12d3e, 0, 0, 0);
        step("t1.adc", 2'd2, 32'hce42, 32'h5efb, 1'b0, 32'h12d3d, 0, 0, 0);

        step("t2.and", 2'd0, 32'h56e0, 32'ha759, 1'b1, 32'h0640, 0, 0, 0);
        step("t2.or",  2'd1, 32'h56e0, 32'ha759, 1'b1, 32'hf7f9, 0, 0, 0);
        step("t2.add", 2'd2, 32'h56e0, 32'ha759, 1'b1, 32'hfe3a, 0, 0, 0);
        step("t2.adc", 2'd2, 32'h56e0, 32'ha759, 1'b0, 32'hfe39, 0, 0, 0);

        step("t3.and", 2'd0, 32'h0, 32'ha759, 1'b1, 32'h0, 0, 1, 0);
        step("t3.or",  2'd1, 32'h0, 32'ha759, 1'b1, 32'ha759, 0, 0, 0);
        step("t3.add", 2'd2, 32'h0, 32'ha759, 1'b1, 32'ha75a, 0, 0, 0);

        step("t4.wrap", 2'd2, 32'hffffffff, 32'h0, 1'b1, 32'h0, 1, 1, 0);
        step("t4.big", 2'd2, 32'h80000000, 32'h80000000, 1'b0,
             32'h0, 1, 1, 1);

        step("t5.eq",  2'd3, 32'd5, 32'd5, 1'b1, 32'h0, 1, 1, 0);
        step("t5.neg", 2'd3, 32'd3, 32'd5, 1'b1, 32'hfffffffe, 0, 0, 0);
        step("t5.ovf", 2'd3, 32'h7fffffff, 32'hffffffff, 1'b1,
             32'h80000000, 0, 0, 1);
        step("t5.sbb", 2'd3, 32'd10, 32'd3, 1'b0, 32'd6, 1, 0, 0);

        step("t6.pre", 2'd1, 32'hf0, 32'h0f, 1'b0, 32'hff, 0, 0, 0);
        drive(2'd2, 32'h100, 32'h23, 1'b0);
        #2;
        chk("t6.hold", result, 32'hff);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6.rst.result", result, 32'h0);
        chk("t6.rst.cout", {31'd0, Cout}, 32'd0);
        chk("t6.rst.zero", {31'd0, zero}, 32'd1);
        rst_n = 1'b1;
        step("t6.post", 2'd2, 32'h100, 32'h23, 1'b0, 32'h123, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
